// File: rtl/matrixmul_loop_sequencer_if.sv
// matrixmul_loop_sequencer_if: ap_ctrl_chain, sub-block handshake and status signals of the loop sequencer
interface matrixmul_loop_sequencer_if #(
    parameter int CNT_W  = 32,
    parameter int ITER_W = 16
);
    logic              ap_start;
    logic              ap_continue;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic              grp_a_start;
    logic              grp_a_ready;
    logic              grp_a_done;
    logic              grp_a_iter;
    logic              grp_b_start;
    logic              grp_b_ready;
    logic              grp_b_done;
    logic              grp_b_iter;
    logic [CNT_W-1:0]  cycle_count;
    logic [ITER_W-1:0] a_iters;
    logic [ITER_W-1:0] b_iters;
    logic              timeout_err;

    modport master (
        output ap_start, ap_continue,
        output grp_a_ready, grp_a_done, grp_a_iter,
        output grp_b_ready, grp_b_done, grp_b_iter,
        input  ap_done, ap_idle, ap_ready, grp_a_start, grp_b_start,
        input  cycle_count, a_iters, b_iters, timeout_err
    );

    modport slave (
        input  ap_start, ap_continue,
        input  grp_a_ready, grp_a_done, grp_a_iter,
        input  grp_b_ready, grp_b_done, grp_b_iter,
        output ap_done, ap_idle, ap_ready, grp_a_start, grp_b_start,
        output cycle_count, a_iters, b_iters, timeout_err
    );
endinterface

// File: rtl/matrixmul_loop_sequencer.sv
// matrixmul_loop_sequencer: runs Row_Col_Product then Row1_Col2 per ap_start, with counters and watchdog
module matrixmul_loop_sequencer #(
    parameter int CNT_W   = 32,
    parameter int ITER_W  = 16,
    parameter int TIMEOUT = 0
) (
    input logic                       ap_clk,
    input logic                       ap_rst,
    matrixmul_loop_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RUN_A, S_RUN_B, S_DONE, S_ERR} state_t;

    localparam logic [31:0] TLIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [ITER_W-1:0] a_iters_q, a_iters_d;
    logic [ITER_W-1:0] b_iters_q, b_iters_d;
    logic              grp_a_start_q, grp_a_start_d;
    logic              grp_b_start_q, grp_b_start_d;
    logic              ap_done_q, ap_done_d;
    logic              ap_idle_q, ap_idle_d;
    logic              ap_ready_q, ap_ready_d;
    logic              timeout_err_q, timeout_err_d;
    logic              run_a, run_b, expired, restart;

    // Next state and all registered outputs; every output is a function of the next state
    always_comb begin
        run_a   = state_q == S_RUN_A;
        run_b   = state_q == S_RUN_B;
        expired = (TIMEOUT > 0) && timer_q == TLIM;
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ap_start) state_d = S_RUN_A;
            S_RUN_A: if (bus.grp_a_done) state_d = S_RUN_B; else if (expired) state_d = S_ERR;
            S_RUN_B: if (bus.grp_b_done) state_d = S_DONE; else if (expired) state_d = S_ERR;
            S_DONE:  if (bus.ap_continue) state_d = bus.ap_start ? S_RUN_A : S_IDLE;
            default: state_d = state_q;
        endcase
        restart       = state_d == S_RUN_A && !run_a;
        timer_d       = (state_d != state_q) ? 32'd0 : (run_a || run_b) ? timer_q + 32'd1 : timer_q;
        cycle_count_d = restart ? '0 :
                        ((run_a || run_b) && !(&cycle_count_q)) ? cycle_count_q + CNT_W'(1) : cycle_count_q;
        a_iters_d     = restart ? '0 :
                        (run_a && bus.grp_a_iter && !(&a_iters_q)) ? a_iters_q + ITER_W'(1) : a_iters_q;
        b_iters_d     = restart ? '0 :
                        (run_b && bus.grp_b_iter && !(&b_iters_q)) ? b_iters_q + ITER_W'(1) : b_iters_q;
        grp_a_start_d = state_d == S_RUN_A && (!run_a || (grp_a_start_q && !bus.grp_a_ready));
        grp_b_start_d = state_d == S_RUN_B && (!run_b || (grp_b_start_q && !bus.grp_b_ready));
        ap_idle_d     = state_d == S_IDLE;
        ap_done_d     = state_d == S_DONE;
        ap_ready_d    = ap_done_d && state_q != S_DONE;
        timeout_err_d = state_d == S_ERR;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            cycle_count_q <= '0;
            a_iters_q     <= '0;
            b_iters_q     <= '0;
            grp_a_start_q <= 1'b0;
            grp_b_start_q <= 1'b0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
            ap_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cycle_count_q <= cycle_count_d;
            a_iters_q     <= a_iters_d;
            b_iters_q     <= b_iters_d;
            grp_a_start_q <= grp_a_start_d;
            grp_b_start_q <= grp_b_start_d;
            ap_done_q     <= ap_done_d;
            ap_idle_q     <= ap_idle_d;
            ap_ready_q    <= ap_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.ap_done     = ap_done_q;
    assign bus.ap_idle     = ap_idle_q;
    assign bus.ap_ready    = ap_ready_q;
    assign bus.grp_a_start = grp_a_start_q;
    assign bus.grp_b_start = grp_b_start_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.a_iters     = a_iters_q;
    assign bus.b_iters     = b_iters_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
